// File: rtl/mem_delay_if.sv
// Processor-side memory bus of mem_delay_ctrl, plus the out-of-band preload port.
interface mem_delay_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic             mem_rd_req;
  logic             mem_wr_req;
  logic [WIDTH-1:0] mem_rd_data;
  logic             mem_ack;
  logic             mem_busy;
  logic             oob_wen;
  logic [31:0]      oob_addr;
  logic [WIDTH-1:0] oob_wr_data;

  modport master (
    output mem_addr, mem_wr_data, mem_rd_req, mem_wr_req,
    output oob_wen, oob_addr, oob_wr_data,
    input  mem_rd_data, mem_ack, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wr_data, mem_rd_req, mem_wr_req,
    input  oob_wen, oob_addr, oob_wr_data,
    output mem_rd_data, mem_ack, mem_busy
  );
endinterface

// File: rtl/mem_delay_ctrl.sv
// Word-addressed memory with a fixed request-to-ack latency; one request in flight,
// requests arriving while busy are dropped.
module mem_delay_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 5
) (
  input logic        clk,
  input logic        rst,
  mem_delay_if.slave mem_if
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 is_rd_q, is_rd_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]     rd_data_q, rd_data_d;
  logic [ADDR_BITS-1:0] idx, oob_idx;
  logic                 idle, wr_acc, rd_acc;
  logic [WIDTH-1:0]     rd_word;

  // Upper address bits are dropped, so out-of-range addresses alias.
  assign idx     = mem_if.mem_addr[ADDR_BITS+1:2];
  assign oob_idx = mem_if.oob_addr[ADDR_BITS+1:2];
  assign idle    = (state_q == S_IDLE);
  assign wr_acc  = idle && mem_if.mem_wr_req;
  assign rd_acc  = idle && mem_if.mem_rd_req && !mem_if.mem_wr_req;

  // A read captures what the array holds after this edge, so bypass a same-word oob write.
  assign rd_word = (mem_if.oob_wen && (oob_idx == idx)) ? mem_if.oob_wr_data : mem_q[idx];

  // Array has no reset; the oob write is last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_acc)         mem_q[idx]     <= mem_if.mem_wr_data;
      if (mem_if.oob_wen) mem_q[oob_idx] <= mem_if.oob_wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    is_rd_d   = is_rd_q;
    hold_d    = hold_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (wr_acc || rd_acc) begin
          busy_d  = 1'b1;
          is_rd_d = rd_acc;
          if (rd_acc) hold_d = rd_word;
          if (LATENCY == 1) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (rd_acc) rd_data_d = rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
          ack_d   = 1'b1;
          if (is_rd_q) rd_data_d = hold_q;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      is_rd_q   <= 1'b0;
      hold_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      is_rd_q   <= is_rd_d;
      hold_q    <= hold_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign mem_if.mem_rd_data = rd_data_q;
  assign mem_if.mem_ack     = ack_q;
  assign mem_if.mem_busy    = busy_q;
endmodule

// File: tb/tb_mem_delay_ctrl.sv
// Bench for mem_delay_ctrl: directed and random traffic on a LATENCY=5 build against a
// cycle-number model, plus a directed LATENCY=1 build.
module tb_mem_delay_ctrl;
  localparam int W   = 32;
  localparam int AB  = 12;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  mem_delay_if #(.WIDTH(W)) bi ();
  mem_delay_if #(.WIDTH(W)) b1 ();

  mem_delay_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_if(bi.slave));
  mem_delay_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .mem_if(b1.slave));

  int checks = 0;
  int errors = 0;

  // Model: word store plus the cycle number of the accepted request.
  logic [W-1:0] m_mem [int];
  bit           m_pend = 0;
  int           m_acc  = 0;
  bit           m_rd   = 0;
  logic [W-1:0] m_cap  = '0;
  logic [W-1:0] m_rdata = '0;
  int           cyc = 0;
  int           pool [8] = '{12'h000, 12'h010, 12'h020, 12'h003, 12'h7ff, 12'hfff, 12'h123, 12'h045};

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AB+1:2]);
  endfunction

  task automatic step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [W-1:0] wd, input bit ow, input logic [31:0] oa,
                      input logic [W-1:0] od);
    bit acc;
    bit e_busy, e_ack;
    rst = r;
    bi.mem_rd_req = rd; bi.mem_wr_req = wr; bi.mem_addr = a; bi.mem_wr_data = wd;
    bi.oob_wen = ow; bi.oob_addr = oa; bi.oob_wr_data = od;
    @(posedge clk);
    acc = 0;
    if (r) begin
      m_pend  = 0;
      m_rdata = '0;
    end else begin
      if ((rd || wr) && !(m_pend && cyc <= m_acc + LAT)) begin
        acc = 1; m_pend = 1; m_acc = cyc; m_rd = !wr;
        if (wr) m_mem[widx(a)] = wd;
      end
      if (ow) m_mem[widx(oa)] = od;
      if (acc && m_rd) m_cap = m_mem.exists(widx(a)) ? m_mem[widx(a)] : 'x;
    end
    cyc++;
    #1;
    e_busy = m_pend && (cyc >= m_acc + 1) && (cyc <= m_acc + LAT);
    e_ack  = m_pend && (cyc == m_acc + LAT);
    if (e_ack && m_rd) m_rdata = m_cap;
    chk($sformatf("busy@%0d", cyc), 32'(bi.mem_busy), 32'(e_busy));
    chk($sformatf("ack@%0d", cyc), 32'(bi.mem_ack), 32'(e_ack));
    chk($sformatf("rd_data@%0d", cyc), bi.mem_rd_data, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(0, 1, 0, a, '0, 0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [W-1:0] d);
    step(0, 0, 1, a, d, 0, '0, '0);
  endtask

  task automatic one1(input bit r, input bit w, input logic [31:0] a, input logic [W-1:0] d,
                      input bit ow);
    b1.mem_rd_req = r; b1.mem_wr_req = w; b1.mem_addr = a; b1.mem_wr_data = d;
    b1.oob_wen = ow; b1.oob_addr = a; b1.oob_wr_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1;
    b1.mem_rd_req = 0; b1.mem_wr_req = 0; b1.mem_addr = '0; b1.mem_wr_data = '0;
    b1.oob_wen = 0; b1.oob_addr = '0; b1.oob_wr_data = '0;

    // Reset, with a request and an oob write that must both be ignored.
    step(1, 1, 0, 32'h0, '0, 1, 32'h0, 32'hBAD0BAD0);
    step(1, 0, 0, '0, '0, 0, '0, '0);

    for (int i = 0; i < 8; i++)
      step(0, 0, 0, '0, '0, 1, 32'(pool[i]) << 2, (i == 0) ? 32'h93 : $urandom);
    idle(1);

    // Preload and read.
    rd(32'h0);
    idle(LAT + 1);
    chk("preload_rd", bi.mem_rd_data, 32'h93);

    // Write then read with byte offset; data must survive the write ack.
    wr(32'h40, 32'hDEADBEEF);
    idle(LAT + 1);
    chk("wr_ack_keeps_data", bi.mem_rd_data, 32'h93);
    rd(32'h43);
    idle(LAT + 1);
    chk("wr_then_rd", bi.mem_rd_data, 32'hDEADBEEF);

    // Requests during busy and ack cycles are dropped; address wraps.
    rd(32'h0);
    for (int i = 0; i < LAT; i++) rd(32'h4040);
    idle(2);
    chk("dropped_reqs", bi.mem_rd_data, 32'h93);
    rd(32'h4040);
    idle(LAT + 1);
    chk("wrap_rd", bi.mem_rd_data, 32'hDEADBEEF);

    // Both requests high: write only.
    step(0, 1, 1, 32'h80, 32'h12345678, 0, '0, '0);
    idle(LAT + 1);
    rd(32'h80);
    idle(LAT + 1);
    chk("simul_rd", bi.mem_rd_data, 32'h12345678);

    // Same-edge oob collisions: oob beats write, read sees oob data.
    step(0, 0, 1, 32'h48c, 32'h11111111, 1, 32'h48c, 32'h22222222);
    idle(LAT + 1);
    rd(32'h48c);
    idle(LAT + 1);
    chk("oob_beats_wr", bi.mem_rd_data, 32'h22222222);
    step(0, 1, 0, 32'h114, '0, 1, 32'h114, 32'h33333333);
    idle(LAT + 1);
    chk("rd_sees_oob", bi.mem_rd_data, 32'h33333333);

    // Reset mid-read, then a request completes normally.
    rd(32'h0);
    idle(1);
    step(1, 0, 0, '0, '0, 0, '0, '0);
    chk("rst_busy", 32'(bi.mem_busy), 32'd0);
    rd(32'h40);
    idle(LAT + 1);
    chk("post_rst_rd", bi.mem_rd_data, 32'hDEADBEEF);

    // Random traffic on the pool of preloaded words.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, oa;
      a  = ($urandom & 32'hFFFF_C003) | (32'(pool[$urandom_range(7)]) << 2);
      oa = ($urandom & 32'hFFFF_C003) | (32'(pool[$urandom_range(7)]) << 2);
      step(($urandom % 60) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0, a, $urandom,
           ($urandom % 6) == 0, oa, $urandom);
    end
    idle(LAT + 1);

    // LATENCY=1 build: requests at c and c+2 ack at c+1 and c+3.
    rst1 = 1'b0;
    one1(0, 0, 32'h14, 32'hA5A50001, 1);
    one1(1, 0, 32'h14, '0, 0);
    chk("l1_ack_c1", 32'(b1.mem_ack), 32'd1);
    chk("l1_busy_c1", 32'(b1.mem_busy), 32'd1);
    chk("l1_data_c1", b1.mem_rd_data, 32'hA5A50001);
    one1(1, 0, 32'h14, '0, 0);
    chk("l1_ack_drop", 32'(b1.mem_ack), 32'd0);
    chk("l1_busy_drop", 32'(b1.mem_busy), 32'd0);
    one1(0, 1, 32'h14, 32'h00005A5A, 0);
    chk("l1_ack_c3", 32'(b1.mem_ack), 32'd1);
    chk("l1_data_c3", b1.mem_rd_data, 32'hA5A50001);
    one1(0, 0, '0, '0, 0);
    one1(1, 0, 32'h14, '0, 0);
    chk("l1_rd_after_wr", b1.mem_rd_data, 32'h00005A5A);
    chk("l1_ack_rd2", 32'(b1.mem_ack), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_delay_ctrl.md
MEM_DELAY_CTRL -- requirements
Module: mem_delay_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, data word width in bits.
REQ-002 Parameter: ADDR_BITS, default 12, word-index bits; array depth = 2**ADDR_BITS words.
REQ-003 Parameter: LATENCY, default 5, cycles from request to ack; legal range 1..15.
REQ-004 Port: clk  input  1  rising-edge clock; sole clock of the block.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: mem_addr  input  32  byte address from the processor.
REQ-007 Port: mem_wr_data  input  WIDTH  store data.
REQ-008 Port: mem_rd_req  input  1  read request, single-cycle pulse.
REQ-009 Port: mem_wr_req  input  1  write request, single-cycle pulse.
REQ-010 Port: mem_rd_data  output  WIDTH  read result, registered.
REQ-011 Port: mem_ack  output  1  completion pulse, registered.
REQ-012 Port: mem_busy  output  1  request in flight, registered.
REQ-013 Port: oob_wen  input  1  out-of-band write enable for bench program preload.
REQ-014 Port: oob_addr  input  32  out-of-band byte address.
REQ-015 Port: oob_wr_data  input  WIDTH  out-of-band write data.

Function
REQ-016 The word index SHALL be addr[ADDR_BITS+1:2]; addr[1:0] and bits above ADDR_BITS+1 are ignored, so out-of-range addresses wrap.
REQ-017 The FSM SHALL have states IDLE, WAIT and ACK, plus a 4-bit down-counter.
REQ-018 In IDLE, a request sampled high at the edge ending cycle c SHALL be accepted; the address, type and write data are latched at that edge.
REQ-019 If both mem_rd_req and mem_wr_req are high in one IDLE cycle, the block SHALL accept a write only.
REQ-020 An accepted write SHALL update the array at the accept edge.
REQ-021 An accepted read SHALL capture array[index] at the accept edge into an internal holding register, reflecting any same-edge oob write.
REQ-022 mem_busy SHALL be 1 in cycles c+1 through c+LATENCY inclusive and 0 otherwise.
REQ-023 mem_ack SHALL be 1 in cycle c+LATENCY only, for exactly one cycle; this cycle is the ACK state.
REQ-024 After accept, the FSM SHALL go to ACK if LATENCY==1, else to WAIT with counter=LATENCY-1.
REQ-025 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to ACK on the edge where the counter equals 1.
REQ-026 From ACK, the FSM SHALL return to IDLE on the next edge.
REQ-027 For reads, mem_rd_data SHALL equal the captured word during the ack cycle and hold that value until the next read ack.
REQ-028 For writes, mem_rd_data SHALL be left unchanged.
REQ-029 Requests arriving in WAIT or ACK SHALL be ignored and never queued; a request in the ACK cycle is dropped, and a new request is accepted no earlier than cycle c+LATENCY+1.
REQ-030 oob_wen SHALL write array[oob index] at any edge, in any state.
REQ-031 If an oob write and an accepted write target the same word at the same edge, the oob data SHALL win.
REQ-032 The array SHALL be uninitialised and SHALL be unaffected by rst.

Reset
REQ-033 While rst is high at an edge, state SHALL become IDLE, counter 0, mem_ack 0, mem_busy 0 and mem_rd_data 0.
REQ-034 Requests and oob writes presented at a reset edge SHALL be ignored.
REQ-035 Reset during WAIT or ACK SHALL abort the in-flight operation with no ack, while any array write already committed at accept persists.
REQ-036 The first request SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-037 Preload and read: oob-write 0x00000093 to byte address 0, rd_req at addr 0 in cycle 10 -> mem_busy high cycles 11-15, mem_ack high in cycle 15 only, mem_rd_data=0x00000093.
REQ-038 Write then read: wr_req addr 0x40 data 0xDEADBEEF, wait for ack, then rd_req addr 0x43 -> read ack returns 0xDEADBEEF; mem_rd_data is unchanged across the write ack.
REQ-039 Busy drop and wrap: rd_req pulses during busy cycles and during the ack cycle -> no extra ack; with ADDR_BITS=12, address 0x4040 returns the word at 0x40.
REQ-040 Simultaneous requests: rd_req and wr_req both high, addr 0x80 data 0x12345678 -> single ack; a later read of 0x80 returns 0x12345678.
REQ-041 Reset mid-operation: rst in cycle c+2 of a read -> no ack, busy 0 the following cycle, and a request issued after rst deasserts completes normally.
REQ-042 LATENCY=1 build: back-to-back requests in cycles c and c+2 -> acks in cycles c+1 and c+3.
